// File: rtl/c17_fi_array.sv
// NCH registered ISCAS-85 c17 channels with a fault-free golden copy each,
// a single-fault injector (bounded or permanent) and a saturating mismatch counter.
module c17_fi_array #(
  parameter int NCH   = 4,
  parameter int CNT_W = 16,
  parameter int DUR_W = 8,
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [5*NCH-1:0]   in_data,
  input  logic               fi_start,
  input  logic [CH_W-1:0]    fi_ch,
  input  logic [2:0]         fi_node,
  input  logic [1:0]         fi_mode,
  input  logic [DUR_W-1:0]   fi_dur,
  input  logic               fi_stop,
  input  logic               cnt_clr,
  output logic               out_valid,
  output logic [2*NCH-1:0]   out_data,
  output logic [2*NCH-1:0]   gold_data,
  output logic [NCH-1:0]     mismatch,
  output logic [CNT_W-1:0]   err_cnt,
  output logic               fi_busy,
  output logic               dbg_fsm_state
);

  // Handshake: in_valid qualifies in_data for one cycle; out_valid qualifies
  // out_data/gold_data/mismatch exactly two edges later. There is no backpressure.

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} fsm_t;

  fsm_t             state_q, state_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [2:0]       node_q, node_d;
  logic [1:0]       mode_q, mode_d;
  logic [DUR_W-1:0] remaining_q, remaining_d;
  logic             perm_q, perm_d;
  logic             req_ok;

  function automatic logic tap(input logic v, input logic hit, input logic [1:0] mode);
    if (!hit) return v;
    case (mode)
      2'd0:    return 1'b0;
      2'd1:    return 1'b1;
      default: return ~v;
    endcase
  endfunction

  // x = {N7,N6,N3,N2,N1}; each gate output may be substituted before fan-out.
  function automatic logic [1:0] c17(input logic [4:0] x, input logic en,
                                     input logic [2:0] node, input logic [1:0] mode);
    logic n10, n11, n16, n19, n22, n23;
    n10 = tap(~(x[0] & x[2]), en && (node == 3'd0), mode);
    n11 = tap(~(x[2] & x[3]), en && (node == 3'd1), mode);
    n16 = tap(~(x[1] & n11),  en && (node == 3'd2), mode);
    n19 = tap(~(n11 & x[4]),  en && (node == 3'd3), mode);
    n22 = tap(~(n10 & n16),   en && (node == 3'd4), mode);
    n23 = tap(~(n16 & n19),   en && (node == 3'd5), mode);
    return {n23, n22};
  endfunction

  assign req_ok = fi_start && !fi_stop && (int'(fi_ch) < NCH) &&
                  (fi_node <= 3'd5) && (fi_mode != 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      node_q      <= '0;
      mode_q      <= '0;
      remaining_q <= '0;
      perm_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      node_q      <= node_d;
      mode_q      <= mode_d;
      remaining_q <= remaining_d;
      perm_q      <= perm_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    node_d      = node_q;
    mode_d      = mode_q;
    remaining_d = remaining_q;
    perm_d      = perm_q;
    case (state_q)
      IDLE: begin
        if (req_ok) begin
          state_d     = ACTIVE;
          ch_d        = fi_ch;
          node_d      = fi_node;
          mode_d      = fi_mode;
          remaining_d = fi_dur;
          perm_d      = (fi_dur == '0);
        end
      end
      ACTIVE: begin
        if (fi_stop) begin
          state_d = IDLE;
        end else if (!perm_q) begin
          if (remaining_q == DUR_W'(1)) state_d = IDLE;
          remaining_d = remaining_q - DUR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fi_busy       = (state_q == ACTIVE);
  assign dbg_fsm_state = state_q;

  logic [5*NCH-1:0] in_q;
  logic             in_v_q;
  logic [2*NCH-1:0] flt_d, gld_d;
  logic [NCH-1:0]   mis_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q   <= '0;
      in_v_q <= 1'b0;
    end else begin
      if (in_valid) in_q <= in_data;
      in_v_q <= in_valid;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic hit;
    assign hit                = fi_busy && (ch_q == CH_W'(c));
    assign flt_d[2*c +: 2]    = c17(in_q[5*c +: 5], hit, node_q, mode_q);
    assign gld_d[2*c +: 2]    = c17(in_q[5*c +: 5], 1'b0, 3'd0, 2'd0);
    assign mis_d[c]           = in_v_q && (flt_d[2*c +: 2] != gld_d[2*c +: 2]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      gold_data <= '0;
      mismatch  <= '0;
    end else begin
      out_valid <= in_v_q;
      out_data  <= flt_d;
      gold_data <= gld_d;
      mismatch  <= mis_d;
    end
  end

  // Clear beats increment; the counter sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (cnt_clr) begin
      err_cnt <= '0;
    end else if (out_valid && (|mismatch) && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_c17_fi_array.sv
// Bench for c17_fi_array: table-driven golden vectors, scoreboard on every
// valid output, and hand sequences for fault windows, stop, saturation and reset.
module tb_c17_fi_array;
  localparam int NCH   = 4;
  localparam int CNT_W = 4;
  localparam int DUR_W = 8;
  localparam int CH_W  = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [5*NCH-1:0] in_data;
  logic             fi_start;
  logic [CH_W-1:0]  fi_ch;
  logic [2:0]       fi_node;
  logic [1:0]       fi_mode;
  logic [DUR_W-1:0] fi_dur;
  logic             fi_stop;
  logic             cnt_clr;
  logic             out_valid;
  logic [2*NCH-1:0] out_data;
  logic [2*NCH-1:0] gold_data;
  logic [NCH-1:0]   mismatch;
  logic [CNT_W-1:0] err_cnt;
  logic             fi_busy;
  logic             dbg_fsm_state;

  c17_fi_array #(.NCH(NCH), .CNT_W(CNT_W), .DUR_W(DUR_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .fi_start(fi_start), .fi_ch(fi_ch), .fi_node(fi_node), .fi_mode(fi_mode),
    .fi_dur(fi_dur), .fi_stop(fi_stop), .cnt_clr(cnt_clr),
    .out_valid(out_valid), .out_data(out_data), .gold_data(gold_data),
    .mismatch(mismatch), .err_cnt(err_cnt), .fi_busy(fi_busy),
    .dbg_fsm_state(dbg_fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [19:0] exp_q[$];   // {out[7:0], gold[7:0], mis[3:0]}
  logic mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Sum-of-products form of the c17 outputs, independent of the gate netlist.
  function automatic logic [1:0] gold1(input logic [4:0] x);
    logic n1, n2, n3, n6, n7;
    {n7, n6, n3, n2, n1} = x;
    return {(~(n3 & n6) & (n2 | n7)), ((n1 & n3) | (n2 & ~(n3 & n6)))};
  endfunction

  function automatic logic [7:0] gold_all(input logic [19:0] d);
    logic [7:0] g;
    for (int c = 0; c < NCH; c++) g[2*c +: 2] = gold1(d[5*c +: 5]);
    return g;
  endfunction

  always @(negedge clk) begin
    logic [19:0] e;
    if (rst_n && mon_en) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected act=out_valid exp=no_output");
        end else begin
          e = exp_q.pop_front();
          check("sb_out", 32'(out_data), 32'(e[19:12]));
          check("sb_gold", 32'(gold_data), 32'(e[11:4]));
          check("sb_mis", 32'(mismatch), 32'(e[3:0]));
        end
      end else begin
        check("mis_idle", 32'(mismatch), 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic v, input logic [19:0] d, input logic [7:0] eo);
    logic [7:0] g;
    logic [3:0] m;
    in_valid = v;
    in_data  = d;
    if (v) begin
      g = gold_all(d);
      for (int c = 0; c < NCH; c++) m[c] = (eo[2*c +: 2] != g[2*c +: 2]);
      exp_q.push_back({eo, g, m});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_fi(input logic st, input logic [1:0] ch, input logic [2:0] node,
                        input logic [1:0] mode, input logic [7:0] dur);
    fi_start = st;
    fi_ch    = ch;
    fi_node  = node;
    fi_mode  = mode;
    fi_dur   = dur;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0);
  endtask

  task automatic clear_cnt();
    cnt_clr = 1'b1;
    cycle(1'b0, '0, '0);
    cnt_clr = 1'b0;
    check("cnt_clear", 32'(err_cnt), 32'd0);
  endtask

  typedef struct {
    logic [4:0] in;
    logic [1:0] exp;
  } vec_t;
  vec_t vecs[7];

  localparam logic [19:0] ONES  = 20'hFFFFF;
  localparam logic [19:0] ZEROS = 20'h00000;

  // ---------------- test sequence ----------------
  initial begin
    logic [19:0] d;
    vecs[0] = '{5'b11111, 2'b01};
    vecs[1] = '{5'b00000, 2'b00};
    vecs[2] = '{5'b00001, 2'b00};
    vecs[3] = '{5'b00010, 2'b11};
    vecs[4] = '{5'b01100, 2'b00};
    vecs[5] = '{5'b10000, 2'b10};
    vecs[6] = '{5'b00101, 2'b01};

    rst_n = 1'b0; in_valid = 1'b1; in_data = ONES;
    set_fi(1'b1, 2'd1, 3'd4, 2'd0, 8'd5);
    fi_stop = 1'b0; cnt_clr = 1'b0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("rst_hold_valid", 32'(out_valid), 32'd0);
    check("rst_hold_gold", 32'(gold_data), 32'd0);
    check("rst_hold_mis", 32'(mismatch), 32'd0);
    check("rst_hold_cnt", 32'(err_cnt), 32'd0);
    check("rst_hold_busy", 32'(fi_busy), 32'd0);
    rst_n = 1'b1; in_valid = 1'b0; fi_start = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // Two-edge latency on a lone sample
    cycle(1'b1, ONES, gold_all(ONES));
    check("lat_edge1_valid", 32'(out_valid), 32'd0);
    cycle(1'b0, '0, '0);
    check("lat_edge2_valid", 32'(out_valid), 32'd1);
    check("lat_edge2_out", 32'(out_data), 32'h55);
    idle(2);

    // Table-driven spot vectors on channel 0
    foreach (vecs[i]) cycle(1'b1, {15'd0, vecs[i].in}, {6'd0, vecs[i].exp});
    // All 32 patterns, rotated across channels
    for (int p = 0; p < 32; p++) begin
      for (int c = 0; c < NCH; c++) d[5*c +: 5] = 5'((p + 7*c) % 32);
      cycle(1'b1, d, gold_all(d));
    end
    for (int i = 0; i < 8; i++) begin
      d = 20'($urandom_range(0, 20'hFFFFF));
      cycle(i % 3 != 0, d, gold_all(d));
    end
    idle(3);
    check("golden_err_cnt", 32'(err_cnt), 32'd0);

    // Bounded stuck-at-0 on N22, channel 2, three cycles
    for (int i = 0; i < 6; i++) begin
      if (i == 0) set_fi(1'b1, 2'd2, 3'd4, 2'd0, 8'd3);
      cycle(1'b1, ONES, (i < 3) ? 8'b01000101 : 8'b01010101);
      fi_start = 1'b0;
      check("sa0_busy", 32'(fi_busy), (i < 3) ? 32'd1 : 32'd0);
    end
    idle(3);
    check("sa0_err_cnt", 32'(err_cnt), 32'd3);
    clear_cnt();

    // Permanent flip on N23, channel 1, then stop
    for (int i = 0; i < 6; i++) begin
      if (i == 0) set_fi(1'b1, 2'd1, 3'd5, 2'd2, 8'd0);
      cycle(1'b1, ZEROS, 8'b00001000);
      fi_start = 1'b0;
      check("flip_busy", 32'(fi_busy), 32'd1);
    end
    fi_stop = 1'b1;
    cycle(1'b1, ZEROS, 8'h00);
    fi_stop = 1'b0;
    check("stop_busy", 32'(fi_busy), 32'd0);
    cycle(1'b1, ZEROS, 8'h00);
    idle(3);
    check("flip_err_cnt", 32'(err_cnt), 32'd6);
    clear_cnt();

    // Invalid requests are ignored
    set_fi(1'b1, 2'd0, 3'd6, 2'd0, 8'd4);
    cycle(1'b1, ONES, 8'h55);
    check("bad_node_busy", 32'(fi_busy), 32'd0);
    set_fi(1'b1, 2'd0, 3'd4, 2'd3, 8'd4);
    cycle(1'b1, ONES, 8'h55);
    check("bad_mode_busy", 32'(fi_busy), 32'd0);
    set_fi(1'b1, 2'd0, 3'd4, 2'd0, 8'd4);
    fi_stop = 1'b1;
    cycle(1'b1, ONES, 8'h55);
    fi_stop = 1'b0;
    check("start_with_stop_busy", 32'(fi_busy), 32'd0);

    // Overlapping start during ACTIVE must not retarget or extend the fault
    for (int i = 0; i < 7; i++) begin
      if (i == 0) set_fi(1'b1, 2'd0, 3'd4, 2'd0, 8'd4);
      if (i == 1) set_fi(1'b1, 2'd3, 3'd5, 2'd1, 8'd8);
      cycle(1'b1, ONES, (i < 4) ? 8'b01010100 : 8'b01010101);
      fi_start = 1'b0;
      check("overlap_busy", 32'(fi_busy), (i < 4) ? 32'd1 : 32'd0);
    end
    idle(3);
    check("overlap_err_cnt", 32'(err_cnt), 32'd4);
    clear_cnt();

    // Saturation at 15 with a 20-cycle permanent fault
    for (int i = 0; i < 20; i++) begin
      if (i == 0) set_fi(1'b1, 2'd3, 3'd5, 2'd2, 8'd0);
      cycle(1'b1, ZEROS, 8'b10000000);
      fi_start = 1'b0;
    end
    fi_stop = 1'b1;
    cycle(1'b1, ZEROS, 8'h00);
    fi_stop = 1'b0;
    idle(3);
    check("sat_err_cnt", 32'(err_cnt), 32'd15);
    clear_cnt();

    // Clear wins over a simultaneous increment
    for (int i = 0; i < 6; i++) begin
      if (i == 0) set_fi(1'b1, 2'd3, 3'd5, 2'd2, 8'd0);
      if (i == 4) cnt_clr = 1'b1;
      cycle(1'b1, ZEROS, 8'b10000000);
      fi_start = 1'b0;
      if (i == 4) begin
        cnt_clr = 1'b0;
        check("clr_vs_inc", 32'(err_cnt), 32'd0);
      end
    end
    fi_stop = 1'b1;
    cycle(1'b1, ZEROS, 8'h00);
    fi_stop = 1'b0;
    idle(3);
    check("post_clr_err_cnt", 32'(err_cnt), 32'd3);
    clear_cnt();

    // Reset in the middle of a dur=10 fault
    for (int i = 0; i < 3; i++) begin
      if (i == 0) set_fi(1'b1, 2'd0, 3'd4, 2'd0, 8'd10);
      cycle(1'b1, ONES, 8'b01010100);
      fi_start = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_out", 32'(out_data), 32'd0);
    check("midrst_busy", 32'(fi_busy), 32'd0);
    check("midrst_cnt", 32'(err_cnt), 32'd0);
    exp_q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("postrst_busy", 32'(fi_busy), 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b1, ONES, 8'h55);
    idle(3);
    check("postrst_err_cnt", 32'(err_cnt), 32'd0);
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/c17_fi_array.md
# c17_fi_array

Parametrised fault-injection test block built around the ISCAS-85 c17 benchmark. It holds NCH independent registered c17 channels plus a fault-free golden copy of each channel. A single fault can be injected on one internal node of one channel, either for a bounded number of cycles or permanently. Faulty outputs are compared against golden outputs, and mismatching output cycles are counted, so host software can run fault campaigns without reloading the design.

## Interface
- NCH, 4: number of c17 channels (1..16)
- CNT_W, 16: width of the error counter
- DUR_W, 8: width of the fault-duration field
- CH_W, derived: max(1, $clog2(NCH)), width of FI_CH
- CLK  in  1  rising-edge clock; the only clock
- RST_N  in  1  asynchronous, active-low reset
- IN_VALID  in  1  input sample valid
- IN_DATA  in  5*NCH  channel c occupies bits [5c+4:5c] = {N7,N6,N3,N2,N1}
- FI_START  in  1  request to start a fault
- FI_CH  in  CH_W  target channel
- FI_NODE  in  3  target node: 0=N10, 1=N11, 2=N16, 3=N19, 4=N22, 5=N23 (6,7 invalid)
- FI_MODE  in  2  0=stuck-at-0, 1=stuck-at-1, 2=bit-flip (3 invalid)
- FI_DUR  in  DUR_W  number of active cycles; 0 means permanent until FI_STOP
- FI_STOP  in  1  abort the active fault
- CNT_CLR  in  1  synchronous clear of ERR_CNT
- OUT_VALID  out  1  output sample valid
- OUT_DATA  out  2*NCH  faulty-path outputs; channel c = bits [2c+1:2c] = {N23,N22}
- GOLD_DATA  out  2*NCH  golden-path outputs, same packing as OUT_DATA
- MISMATCH  out  NCH  per-channel OUT_DATA != GOLD_DATA
- ERR_CNT  out  CNT_W  count of output cycles with any mismatch
- FI_BUSY  out  1  high while the FSM is in ACTIVE

## Operation
- **Datapath.** Per channel: a 5-bit input register, c17 logic of six NAND2 gates, and a 2-bit output register.
  - c17 logic: N10=!(N1&N3), N11=!(N3&N6), N16=!(N2&N11), N19=!(N11&N7), N22=!(N10&N16), N23=!(N16&N19).
  - The golden path shares the input register and duplicates the logic and output register, with no fault taps.
- **Input capture.** Input registers load IN_DATA only when IN_VALID=1 and hold otherwise. A valid shift register tracks IN_VALID through both register stages.
- **Fault tap.** Applied only on the faulty path, at node FI_NODE of channel FI_CH, and only while the FSM is in ACTIVE.
  - The substituted value propagates to downstream gates.
  - Stuck-at modes force the node to 0 or 1; flip mode inverts it.
- **FSM states.** IDLE and ACTIVE. Internal registers: ch, node, mode, remaining counter (DUR_W bits), permanent flag.
- **IDLE to ACTIVE.** Taken on FI_START=1, FI_STOP=0, FI_CH<NCH, FI_NODE<=5 and FI_MODE!=3. All fields are latched; permanent flag = (FI_DUR==0); remaining = FI_DUR.
  - An invalid request is ignored and the FSM stays in IDLE.
- **ACTIVE.** If not permanent, remaining decrements each cycle; the FSM moves to IDLE at the edge where remaining==1.
  - FI_STOP=1 forces IDLE at the next edge and has priority over everything else.
  - FI_START during ACTIVE is ignored.
- **Compare.** MISMATCH[c] is registered alongside the output registers and is forced to 0 when that output sample is not valid.
- **Error counter.** ERR_CNT increments by 1 on each edge where OUT_VALID=1 and |MISMATCH=1, saturating at 2^CNT_W-1.
  - CNT_CLR=1 sets ERR_CNT to 0 and wins over a simultaneous increment.
- **Reset (RST_N low).** All registers clear immediately: OUT_VALID=0, OUT_DATA=0, GOLD_DATA=0, MISMATCH=0, ERR_CNT=0, FI_BUSY=0, FSM=IDLE. No fault is applied while in reset.
- **Reset during ACTIVE.** The fault is cancelled; after release the block resumes in IDLE.

## Timing
- **Data latency.** A sample presented with IN_VALID at edge k appears on OUT_DATA/GOLD_DATA/MISMATCH with OUT_VALID=1 after edge k+1. ERR_CNT reflects it after edge k+2. Throughput is one sample per cycle.
- **Fault window.** FI_START accepted at edge t gives FI_BUSY=1 after edge t. Output registers captured at edges t+1 .. t+FI_DUR use faulty values, so the sample loaded at edge t is the first one affected. FI_BUSY falls after edge t+FI_DUR.
- **Stop.** FI_STOP sampled at edge s gives FI_BUSY=0 after edge s. Outputs captured at edge s+1 are fault-free.
- **Back-to-back faults.** A new FI_START is accepted only when FI_BUSY=0, i.e. on the cycle after ACTIVE ends at the earliest.

## Test plan
- **Reset and golden path.** Hold reset, then stream all 32 input patterns for one channel. Required: all outputs 0 during reset; afterwards OUT_DATA==GOLD_DATA with latency 2. Spot checks: input 11111 gives {N23,N22}=01; input 00000 gives 00. ERR_CNT stays 0.
- **Bounded stuck-at.** Inputs all-1 on every channel; FI_START with ch=2, node=4 (N22), mode=0, dur=3. Required: channel 2 reads {0,0} against golden {0,1} for exactly 3 valid outputs; MISMATCH=0100; ERR_CNT=3; FI_BUSY high for 3 cycles.
- **Permanent flip and stop.** Inputs 00000; node=5 (N23), mode=2, dur=0. Required: faulty output {1,0} persists until FI_STOP. FI_BUSY drops the cycle after FI_STOP; the next output matches golden.
- **Invalid and overlapping requests.** FI_START with node=6 is ignored (FI_BUSY stays 0). FI_START with mode=3 is ignored. A second FI_START during ACTIVE does not change ch/node/mode or the remaining duration.
- **Counter saturation and clear.** With CNT_W=4, run a permanent fault for 20 mismatching cycles. Required: ERR_CNT saturates at 15. CNT_CLR asserted together with a mismatch leaves ERR_CNT=0.
- **Mid-fault reset.** Assert RST_N low during a dur=10 fault. Required: outputs clear asynchronously; after release FI_BUSY=0 and outputs match golden.
